// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// State and grant encodings plus the round-robin pick rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

  // On a tie the side that did not win last time goes next.
  function automatic gnt_t rr_pick(
    input logic i_req,
    input logic d_req,
    input gnt_t last
  );
    if (i_req && d_req)
      return (last == GNT_I) ? GNT_D : GNT_I;
    return d_req ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter sequencing the memory access cycles.
// Loads LATENCY-1 on grant; zero marks the final access cycle.
module mem_lat_counter #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(LATENCY + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= CW'(LATENCY - 1);
    else if (dec && (cnt != '0))
      cnt <= cnt - CW'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slow unified memory between
// the fetch port and the load/store port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_t        state;
  state_t        state_nx;
  gnt_t          last_gnt;
  gnt_t          pick;
  logic          grant;
  logic          zero;
  logic          final_cyc;
  logic [AW-3:0] addr_q;
  logic          we_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          unused_lsb;

  // Accesses are word-aligned; byte offset is dropped.
  assign unused_lsb = ^{i_addr[1:0], d_addr[1:0]};

  assign pick      = rr_pick(i_req, d_req, last_gnt);
  assign grant     = (state == ST_IDLE) && (i_req || d_req);
  assign final_cyc = (state == ST_WAIT) && zero;

  mem_lat_counter #(
    .LATENCY(LATENCY)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (grant),
    .dec  (state == ST_WAIT),
    .zero (zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (i_req || d_req) state_nx = ST_WAIT;
      ST_WAIT: if (zero) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en = 1'b0;
    mem_we = 1'b0;
    i_ack  = 1'b0;
    d_ack  = 1'b0;
    busy   = 1'b1;
    unique case (state)
      ST_IDLE: busy = 1'b0;
      ST_WAIT: begin
        mem_en = 1'b1;
        mem_we = zero && we_q;
      end
      ST_DONE: begin
        i_ack = (last_gnt == GNT_I);
        d_ack = (last_gnt == GNT_D);
      end
      default: busy = 1'b0;
    endcase
  end

  // last_gnt doubles as the owner of the access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt <= GNT_I;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
    end else if (grant) begin
      last_gnt <= pick;
      if (pick == GNT_D) begin
        addr_q  <= d_addr[AW-1:2];
        we_q    <= d_we;
        wdata_q <= d_wdata;
      end else begin
        addr_q  <= i_addr[AW-1:2];
        we_q    <= 1'b0;
        wdata_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (final_cyc) begin
      if (last_gnt == GNT_I)
        i_rdata_q <= mem_rdata;
      else if (!we_q)
        d_rdata_q <= mem_rdata;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases plus random traffic
// against a transaction-level timing model.
module tb_mem_arbiter;

  localparam int L = 4;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        i1_req;
  logic [31:0] i1_addr;
  logic        i1_ack;
  logic [31:0] i1_rdata;
  logic        d1_req;
  logic        d1_we;
  logic [31:0] d1_addr;
  logic [31:0] d1_wdata;
  logic        d1_ack;
  logic [31:0] d1_rdata;
  logic        m1_en;
  logic        m1_we;
  logic [29:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        busy1;

  mem_arbiter #(.LATENCY(L), .AW(32), .DW(32)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i1_req), .i_addr(i1_addr),
    .i_ack(i1_ack), .i_rdata(i1_rdata),
    .d_req(d1_req), .d_we(d1_we),
    .d_addr(d1_addr), .d_wdata(d1_wdata),
    .d_ack(d1_ack), .d_rdata(d1_rdata),
    .mem_en(m1_en), .mem_we(m1_we),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [64];
  logic [31:0] seed [64];
  logic [31:0] ref_mem [64];
  logic        pl;

  always @(posedge clk) begin
    if (pl) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed[i];
    end else if (mem_en && mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr[5:0]];
  assign m1_rdata  = 32'hC0DE0000 | {2'b00, m1_addr};

  int n_chk;
  int n_pass;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic preload();
    pl = 1'b1;
    @(negedge clk);
    pl = 1'b0;
  endtask

  int i_first, i_cnt, d_first, d_cnt, we_cnt;
  logic [29:0] we_addr;
  logic [31:0] we_data;

  task automatic window(input int n, input int drop_i, input int drop_d);
    i_first = 0; i_cnt = 0; d_first = 0; d_cnt = 0; we_cnt = 0;
    we_addr = '0; we_data = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (i_ack) begin
        i_cnt++;
        if (i_first == 0) i_first = k;
      end
      if (d_ack) begin
        d_cnt++;
        if (d_first == 0) d_first = k;
      end
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr;
        we_data = mem_wdata;
      end
      if (k == drop_i) i_req = 1'b0;
      if (k == drop_d) d_req = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {i_ack, d_ack, mem_en, mem_we, busy}, 5'b0);
    chk({tag, "_addr"}, mem_addr, 30'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_rdata"}, {i_rdata, d_rdata}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Random-phase model state
  int          tg, free_e, gside;
  bit          gwe, last;
  logic [31:0] gaddr, gwdata, gdata;
  bit          inflight [2];
  logic [31:0] exp_ir, exp_dr;
  bit          ir_v, dr_v;
  bit          ebusy, een, ewe, eack;

  int acks, prev_k, we_tot, dtot;
  bit side, prev_side;

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b0; pl = 1'b0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    i1_req = 0; i1_addr = 0; d1_req = 0; d1_we = 0; d1_addr = 0;
    d1_wdata = 0;
    for (int i = 0; i < 64; i++) seed[i] = $urandom;
    seed[3] = 32'h8C220004;
    seed[4] = 32'h11111111;
    @(negedge clk);
    preload();
    check_zero("rst_init");
    rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of a store
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_busy", {busy, mem_en, mem_we}, 3'b110);
    chk("t1_maddr", mem_addr, 30'd4);
    @(negedge clk);
    rst = 1'b0; d_req = 0; d_we = 0;
    #1;
    check_zero("t1_rst");
    window(4, 0, 0);
    we_tot = we_cnt; dtot = d_cnt;
    rst = 1'b1;
    window(6, 0, 0);
    chk("t1_no_we", we_tot + we_cnt, 0);
    chk("t1_no_ack", dtot + d_cnt, 0);
    chk("t1_mem4", mem[4], 32'h11111111);

    // Fetch alone
    i_req = 1; i_addr = 32'h0C;
    window(8, 5, 0);
    chk("t2_ack_cyc", i_first, 5);
    chk("t2_ack_cnt", i_cnt, 1);
    chk("t2_dack", d_cnt, 0);
    chk("t2_rdata", i_rdata, 32'h8C220004);

    // Store then load
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
    window(8, 0, 5);
    chk("t3_we_cnt", we_cnt, 1);
    chk("t3_we_addr", we_addr, 30'd8);
    chk("t3_we_data", we_data, 32'h12345678);
    chk("t3_st_ack", d_first, 5);
    chk("t3_st_rdata", d_rdata, 32'd0);
    d_req = 1; d_we = 0; d_addr = 32'h23;
    window(8, 0, 5);
    chk("t3_ld_ack", d_first, 5);
    chk("t3_ld_we", we_cnt, 0);
    chk("t3_ld_rdata", d_rdata, 32'h12345678);

    // Tie after reset, then a second tie
    do_reset();
    i_req = 1; i_addr = 32'h0C; d_req = 1; d_we = 0; d_addr = 32'h20;
    window(14, 11, 5);
    chk("t4_d_cyc", d_first, 5);
    chk("t4_i_cyc", i_first, 11);
    chk("t4_cnts", {i_cnt[7:0], d_cnt[7:0]}, 16'h0101);
    chk("t4_rdata", {i_rdata, d_rdata}, {32'h8C220004, 32'h12345678});
    i_req = 1; d_req = 1;
    window(14, 11, 5);
    chk("t4b_d_cyc", d_first, 5);
    chk("t4b_i_cyc", i_first, 11);

    // Both held continuously for 20 accesses
    i_req = 1; d_req = 1; acks = 0; prev_k = 0; prev_side = 0;
    for (int k = 1; k <= 20 * (L + 2) + 12 && acks < 20; k++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        side = d_ack;
        if (acks == 0) begin
          chk("t5_first", {k[7:0], side}, {8'd5, 1'b1});
        end else begin
          chk("t5_alt", side, !prev_side);
          chk("t5_gap", k - prev_k, L + 2);
        end
        acks++;
        prev_k = k; prev_side = side;
        if (acks == 20) begin
          i_req = 0; d_req = 0;
        end
      end
    end
    chk("t5_count", acks, 20);
    i_req = 0; d_req = 0;
    repeat (3) @(negedge clk);

    // LATENCY=1 instance: load, request dropped during WAIT
    d1_req = 1; d1_we = 0; d1_addr = 32'h04;
    d_first = 0; d_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("t6_en", {m1_en, m1_we, busy1}, 3'b101);
        d1_req = 0;
      end
      if (d1_ack) begin
        d_cnt++;
        if (d_first == 0) d_first = k;
      end
    end
    chk("t6_ack_cyc", d_first, 2);
    chk("t6_ack_cnt", d_cnt, 1);
    chk("t6_rdata", d1_rdata, 32'hC0DE0001);
    chk("t6_iside", {i1_ack, i1_rdata, m1_wdata}, 65'd0);

    // Random traffic against the timing model
    for (int i = 0; i < 64; i++) begin
      seed[i] = $urandom;
      ref_mem[i] = seed[i];
    end
    preload();
    tg = -100; free_e = 0; last = 0; ir_v = 0; dr_v = 0;
    inflight[0] = 0; inflight[1] = 0;
    for (int e = 0; e < 3000; e++) begin
      if (e > 0) begin
        ebusy = (e >= tg) && (e <= tg + L);
        een   = (e >= tg) && (e <= tg + L - 1);
        ewe   = een && (e == tg + L - 1) && gwe;
        eack  = (e == tg + L);
        if (eack) begin
          inflight[gside] = 0;
          if (gside == 0) begin
            exp_ir = gdata; ir_v = 1; i_req = 0;
          end else begin
            d_req = 0;
            if (!gwe) begin
              exp_dr = gdata; dr_v = 1;
            end
          end
        end
        chk("rnd_ctl", {busy, mem_en, mem_we, i_ack, d_ack},
            {ebusy, een, ewe, eack && gside == 0, eack && gside == 1});
        if (een) chk("rnd_maddr", mem_addr, gaddr[31:2]);
        if (ewe) chk("rnd_mwdata", mem_wdata, gwdata);
        if (ir_v) chk("rnd_irdata", i_rdata, exp_ir);
        if (dr_v) chk("rnd_drdata", d_rdata, exp_dr);
      end
      if (inflight[0] && i_req && $urandom_range(3) == 0) i_req = 0;
      if (inflight[1] && d_req && $urandom_range(3) == 0) d_req = 0;
      if (!inflight[0] && !i_req && $urandom_range(2) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (!inflight[1] && !d_req && $urandom_range(2) == 0) begin
        d_req = 1; d_addr = $urandom;
        d_we = $urandom_range(1) == 1; d_wdata = $urandom;
      end
      if ((e + 1 >= free_e) && (i_req || d_req)) begin
        if (i_req && d_req) gside = last ? 0 : 1;
        else gside = d_req ? 1 : 0;
        last   = gside[0];
        tg     = e + 1;
        free_e = e + 1 + L + 2;
        gaddr  = gside == 1 ? d_addr : i_addr;
        gwe    = gside == 1 ? d_we : 1'b0;
        gwdata = d_wdata;
        gdata  = ref_mem[gaddr[7:2]];
        if (gwe) ref_mem[gaddr[7:2]] = gwdata;
        inflight[gside] = 1;
      end
      @(negedge clk);
    end
    i_req = 0; d_req = 0;
    repeat (8) @(negedge clk);
    chk("end_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
